// File: rtl/sdram_arbiter_if.sv
`default_nettype none
// sdram_arbiter_if: two requester ports plus the SDRAM-controller command side.
// Rev 1.0 - initial release.
interface sdram_arbiter_if #(
  parameter int ADDR_WIDTH = 24
);
  logic                  m0_req_i;
  logic                  m1_req_i;
  logic                  m0_we_i;
  logic                  m1_we_i;
  logic [ADDR_WIDTH-1:0] m0_addr_i;
  logic [ADDR_WIDTH-1:0] m1_addr_i;
  logic [15:0]           m0_wdata_i;
  logic [15:0]           m1_wdata_i;
  logic                  m0_done_o;
  logic                  m1_done_o;
  logic                  m0_err_o;
  logic                  m1_err_o;
  logic [15:0]           rd_data_o;
  logic                  rd_enable_o;
  logic                  wr_enable_o;
  logic                  busy_i;
  logic                  rd_ready_i;
  logic [15:0]           rd_data_i;
  logic [15:0]           wr_data_o;
  logic [ADDR_WIDTH-1:0] addr_o;

  modport slave (
    input  m0_req_i, m1_req_i, m0_we_i, m1_we_i, m0_addr_i, m1_addr_i,
           m0_wdata_i, m1_wdata_i, busy_i, rd_ready_i, rd_data_i,
    output m0_done_o, m1_done_o, m0_err_o, m1_err_o, rd_data_o,
           rd_enable_o, wr_enable_o, wr_data_o, addr_o
  );

  modport master (
    output m0_req_i, m1_req_i, m0_we_i, m1_we_i, m0_addr_i, m1_addr_i,
           m0_wdata_i, m1_wdata_i, busy_i, rd_ready_i, rd_data_i,
    input  m0_done_o, m1_done_o, m0_err_o, m1_err_o, rd_data_o,
           rd_enable_o, wr_enable_o, wr_data_o, addr_o
  );
endinterface
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// sdram_arbiter: round-robin sharing of one SDRAM controller between two ports, with timeout abort.
// Rev 1.0 - initial release.
module sdram_arbiter #(
  parameter int ADDR_WIDTH = 24,
  parameter int TIMEOUT    = 255
) (
  input  logic           clk,
  input  logic           rst,
  sdram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);

  state_t                state;
  logic                  sel;
  logic                  last;
  logic                  we_r;
  logic                  err_r;
  logic [7:0]            tcnt;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [15:0]           wdata_r;
  logic [15:0]           rd_data_r;

  logic any_req;
  logic grant;
  logic completion;
  logic expired;

  always_comb begin
    any_req    = bus.m0_req_i | bus.m1_req_i;
    // On a tie the port that did not win last time is granted.
    grant      = (bus.m0_req_i & bus.m1_req_i) ? ~last : bus.m1_req_i;
    expired    = (tcnt == TCNT_LAST);
    completion = 1'b0;
    case (state)
      ISSUE:   completion = ~we_r & bus.rd_ready_i;
      WAIT:    completion = we_r ? ~bus.busy_i : bus.rd_ready_i;
      default: completion = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= 1'b0;
      last      <= 1'b1;
      we_r      <= 1'b0;
      err_r     <= 1'b0;
      tcnt      <= 8'd0;
      addr_r    <= '0;
      wdata_r   <= 16'd0;
      rd_data_r <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            sel     <= grant;
            last    <= grant;
            we_r    <= grant ? bus.m1_we_i    : bus.m0_we_i;
            addr_r  <= grant ? bus.m1_addr_i  : bus.m0_addr_i;
            wdata_r <= grant ? bus.m1_wdata_i : bus.m0_wdata_i;
            tcnt    <= 8'd0;
            err_r   <= 1'b0;
            state   <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          tcnt <= tcnt + 8'd1;
          // Completion takes priority over a coincident timeout.
          if (completion) begin
            if (!we_r) begin
              rd_data_r <= bus.rd_data_i;
            end
            state <= DONE;
          end else if (expired) begin
            err_r <= 1'b1;
            state <= DONE;
          end else if (state == ISSUE && bus.busy_i) begin
            state <= WAIT;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.wr_enable_o = (state == ISSUE) &  we_r;
  assign bus.rd_enable_o = (state == ISSUE) & ~we_r;
  assign bus.m0_done_o   = (state == DONE)  & ~sel;
  assign bus.m1_done_o   = (state == DONE)  &  sel;
  assign bus.m0_err_o    = bus.m0_done_o & err_r;
  assign bus.m1_err_o    = bus.m1_done_o & err_r;
  assign bus.addr_o      = addr_r;
  assign bus.wr_data_o   = wdata_r;
  assign bus.rd_data_o   = rd_data_r;
endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// tb_sdram_arbiter: directed scenarios with a scripted controller and an in-order completion scoreboard.
module tb_sdram_arbiter;
  logic clk;
  logic rst;

  sdram_arbiter_if #(.ADDR_WIDTH(24)) bus ();

  sdram_arbiter #(.ADDR_WIDTH(24), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        port;
    logic        we;
    logic [23:0] addr;
    logic [15:0] wdata;
    logic        err;
    logic [15:0] rd;
    int          lat;
    int          en;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] hold   = 16'd0;
  int          rcnt   = -1;
  int          en_cnt = 0;
  int          bs = 1, bl = 1, ra = -1;
  logic [15:0] rv = 16'd0;
  int          rearm0 = 0, rearm1 = 0;
  logic        raise0 = 1'b0, raise1 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic port, input logic we, input logic [23:0] addr,
                      input logic [15:0] wdata, input logic err, input logic [15:0] rd_new,
                      input int lat, input int en);
    exp_t e;
    e.port = port; e.we = we; e.addr = addr; e.wdata = wdata; e.err = err;
    e.rd   = (!we && !err) ? rd_new : hold;
    hold   = e.rd;
    e.lat  = lat; e.en = en;
    sb.push_back(e);
  endtask

  task automatic setreq(input logic port, input logic we, input logic [23:0] addr,
                        input logic [15:0] wdata);
    if (port) begin
      bus.m1_we_i = we; bus.m1_addr_i = addr; bus.m1_wdata_i = wdata; bus.m1_req_i = 1'b1;
    end else begin
      bus.m0_we_i = we; bus.m0_addr_i = addr; bus.m0_wdata_i = wdata; bus.m0_req_i = 1'b1;
    end
  endtask

  // One cycle: observe outputs mid-cycle, score completions, then drive the controller side.
  task automatic tick();
    exp_t e;
    logic p;
    @(negedge clk);
    if (raise0) begin bus.m0_req_i = 1'b1; raise0 = 1'b0; end
    if (raise1) begin bus.m1_req_i = 1'b1; raise1 = 1'b0; end
    chk("one_enable", bus.rd_enable_o & bus.wr_enable_o, 0);
    chk("one_done", bus.m0_done_o & bus.m1_done_o, 0);
    if (rcnt >= 0) rcnt++;
    else if (bus.rd_enable_o | bus.wr_enable_o) rcnt = 0;
    if (bus.rd_enable_o | bus.wr_enable_o) begin
      en_cnt++;
      if (sb.size() > 0) chk("enable_kind", bus.wr_enable_o, sb[0].we);
    end
    if (bus.m0_done_o | bus.m1_done_o) begin
      p = bus.m1_done_o;
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("grant_port", p, e.port);
        chk("err", p ? bus.m1_err_o : bus.m0_err_o, e.err);
        chk("rd_data", bus.rd_data_o, e.rd);
        chk("addr", bus.addr_o, e.addr);
        chk("wr_data", bus.wr_data_o, e.wdata);
        chk("done_latency", rcnt, e.lat);
        chk("enable_cycles", en_cnt, e.en);
      end
      if (p) begin
        bus.m1_req_i = 1'b0;
        if (rearm1 > 0) begin rearm1--; raise1 = 1'b1; end
      end else begin
        bus.m0_req_i = 1'b0;
        if (rearm0 > 0) begin rearm0--; raise0 = 1'b1; end
      end
      rcnt   = -1;
      en_cnt = 0;
    end
    bus.busy_i     = (rcnt >= 0) && (rcnt >= bs) && (rcnt < bs + bl);
    bus.rd_ready_i = (rcnt >= 0) && (rcnt == ra);
    bus.rd_data_i  = bus.rd_ready_i ? rv : 16'hDEAD;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (sb.size() > 0 && n < max) begin
      tick();
      n++;
    end
    chk("drain_bound", sb.size(), 0);
    sb.delete();
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rcnt = -1; en_cnt = 0; hold = 16'd0;
    bus.busy_i = 1'b0; bus.rd_ready_i = 1'b0;
  endtask

  initial begin
    bus.m0_req_i = 1'b0; bus.m1_req_i = 1'b0; bus.m0_we_i = 1'b0; bus.m1_we_i = 1'b0;
    bus.m0_addr_i = '0; bus.m1_addr_i = '0; bus.m0_wdata_i = '0; bus.m1_wdata_i = '0;
    bus.busy_i = 1'b0; bus.rd_ready_i = 1'b0; bus.rd_data_i = 16'd0;
    do_reset();
    tick();
    chk("rst_wr_en", bus.wr_enable_o, 0);
    chk("rst_rd_en", bus.rd_enable_o, 0);
    chk("rst_dones", {bus.m0_done_o, bus.m1_done_o, bus.m0_err_o, bus.m1_err_o}, 0);
    chk("rst_addr", bus.addr_o, 0);
    chk("rst_wdata", bus.wr_data_o, 0);
    chk("rst_rdata", bus.rd_data_o, 0);
    rst = 1'b0;
    tick();

    // Single m0 write; busy for three cycles starting one cycle after enable.
    bs = 1; bl = 3; ra = -1;
    setreq(1'b0, 1'b1, 24'h000010, 16'hBEEF);
    push(1'b0, 1'b1, 24'h000010, 16'hBEEF, 1'b0, 16'h0, 5, 2);
    drain(40);

    // Single m1 read; data arrives three cycles after busy.
    bs = 1; bl = 1; ra = 4; rv = 16'h1234;
    setreq(1'b1, 1'b0, 24'hFFFFFF, 16'h0000);
    push(1'b1, 1'b0, 24'hFFFFFF, 16'h0000, 1'b0, 16'h1234, 5, 2);
    drain(40);

    // Both ports request continuously from reset.
    do_reset();
    bs = 1; bl = 1; ra = -1;
    setreq(1'b0, 1'b1, 24'h000100, 16'h1111);
    setreq(1'b1, 1'b1, 24'h000200, 16'h2222);
    rearm0 = 1; rearm1 = 1;
    tick();
    rst = 1'b0;
    push(1'b0, 1'b1, 24'h000100, 16'h1111, 1'b0, 16'h0, 3, 2);
    push(1'b1, 1'b1, 24'h000200, 16'h2222, 1'b0, 16'h0, 3, 2);
    push(1'b0, 1'b1, 24'h000100, 16'h1111, 1'b0, 16'h0, 3, 2);
    push(1'b1, 1'b1, 24'h000200, 16'h2222, 1'b0, 16'h0, 3, 2);
    drain(80);

    // Timeout: controller never responds to an m0 read.
    bs = 0; bl = 0; ra = -1;
    setreq(1'b0, 1'b0, 24'h00ABCD, 16'h0000);
    push(1'b0, 1'b0, 24'h00ABCD, 16'h0000, 1'b1, 16'h0, 8, 8);
    drain(40);

    // Normal service after the abort.
    bs = 1; bl = 1; ra = -1;
    setreq(1'b1, 1'b1, 24'h000042, 16'hC0DE);
    push(1'b1, 1'b1, 24'h000042, 16'hC0DE, 1'b0, 16'h0, 3, 2);
    drain(40);

    // Read data lands exactly on the last allowed cycle.
    bs = 1; bl = 1; ra = 7; rv = 16'hA5A5;
    setreq(1'b1, 1'b0, 24'h000777, 16'h0000);
    push(1'b1, 1'b0, 24'h000777, 16'h0000, 1'b0, 16'hA5A5, 8, 2);
    drain(40);

    // Reset during WAIT of an m0 write with m1 pending.
    bs = 1; bl = 100; ra = -1;
    setreq(1'b0, 1'b1, 24'h00003C, 16'h5A5A);
    for (int i = 0; i < 10 && rcnt != 3; i++) tick();
    chk("reached_wait", rcnt, 3);
    setreq(1'b1, 1'b1, 24'h000099, 16'h9999);
    do_reset();
    #1;
    chk("midrst_wr_en", bus.wr_enable_o, 0);
    chk("midrst_rd_en", bus.rd_enable_o, 0);
    chk("midrst_addr", bus.addr_o, 0);
    chk("midrst_wdata", bus.wr_data_o, 0);
    chk("midrst_done", {bus.m0_done_o, bus.m1_done_o}, 0);
    sb.delete();
    bl = 1;
    tick();
    tick();
    push(1'b0, 1'b1, 24'h00003C, 16'h5A5A, 1'b0, 16'h0, 3, 2);
    push(1'b1, 1'b1, 24'h000099, 16'h9999, 1'b0, 16'h0, 3, 2);
    rst = 1'b0;
    drain(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-port round-robin arbiter that shares the single SDRAM controller command interface between two requesters, e.g. the memory tester and a debug/host port. It serialises requests, drives the controller's enable/busy/ready handshake, returns read data and a per-port completion pulse, and aborts any transfer the controller fails to accept or finish within a timeout.

## Interface
- ADDR_WIDTH, 24: SDRAM word address width.
- TIMEOUT, 255: maximum cycles a transfer may spend in ISSUE+WAIT before abort; 2..255; the counter is 8 bits.

- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- m0_req_i / m1_req_i  input  1  request; held high until the port's done pulse.
- m0_we_i / m1_we_i  input  1  1 = write, 0 = read; stable while req is high.
- m0_addr_i / m1_addr_i  input  ADDR_WIDTH  word address; stable while req is high.
- m0_wdata_i / m1_wdata_i  input  16  write data; stable while req is high.
- m0_done_o / m1_done_o  output  1  one-cycle completion pulse.
- m0_err_o / m1_err_o  output  1  high with done when the transfer timed out.
- rd_data_o  output  16  read data; valid in the done cycle of a successful read, held until the next successful read.
- rd_enable_o  output  1  read command to the controller.
- wr_enable_o  output  1  write command to the controller.
- busy_i  input  1  controller busy.
- rd_ready_i  input  1  controller read data valid, 1 cycle.
- rd_data_i  input  16  controller read data.
- wr_data_o  output  16  write data to the controller.
- addr_o  output  ADDR_WIDTH  address to the controller.

## Operation
- Registered state: IDLE, ISSUE, WAIT, DONE. Also registered: sel (granted port), we_r, addr_o, wr_data_o, last (last granted port), tcnt (8-bit), err_r, rd_data_o.
- IDLE:
  - If any req is high, grant a port:
    - single requester wins;
    - if both request, grant the port != last.
  - On grant: latch sel, we_r, addr_o, wr_data_o; set last <= sel; clear tcnt and err_r; go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE:
  - wr_enable_o = we_r; rd_enable_o = ~we_r. Both are decoded from registered state only.
  - busy_i=1 -> WAIT.
  - For a read, rd_ready_i=1 in ISSUE counts as completion: capture data and go to DONE.
- WAIT:
  - Write: busy_i=0 -> DONE.
  - Read: rd_ready_i=1 -> rd_data_o <= rd_data_i, then DONE.
  - Enables are low.
- Timeout:
  - tcnt increments each cycle in ISSUE/WAIT.
  - If tcnt == TIMEOUT-1 and there is no completion that cycle: err_r <= 1 and go to DONE.
  - If completion and timeout coincide, completion wins and err stays 0.
  - On a timed-out read, rd_data_o is not updated.
- DONE:
  - mN_done_o = (state==DONE && sel==N); mN_err_o = mN_done_o & err_r.
  - Go to IDLE unconditionally.
- Requester contract: req must drop at the clock edge that ends the DONE cycle. The arbiter samples req only in IDLE, so there is no spurious re-grant.
- addr_o and wr_data_o stay constant from ISSUE through DONE.
- Requests arriving outside IDLE wait; they are never lost while req stays high.

## Timing
- Reset (async, immediate):
  - state=IDLE, last=1 (m0 wins the first tie), sel=0, tcnt=0, err_r=0;
  - all outputs 0: enables, dones, errs, addr_o, wr_data_o, rd_data_o.
- Grant latency: req high in IDLE cycle N -> enable high in cycle N+1.
- Enable stays high from ISSUE entry until the cycle after busy_i is first sampled high.
- Write latency: done = 1 cycle after the first sampled busy_i=0 in WAIT.
- Read latency: done = 1 cycle after rd_ready_i; rd_data_o is valid in that same cycle.
- Back-to-back: minimum 4 cycles per transfer (IDLE, ISSUE, WAIT, DONE) when busy_i responds in 1 cycle; read fast path through ISSUE is 3 cycles.
- Reset asserted mid-transfer: returns to IDLE immediately with outputs 0. No done is issued for the abandoned transfer.

## Test plan
- Single m0 write:
  - Stimulus: addr=0x000010, wdata=0xBEEF; busy_i high 1 cycle after enable for 3 cycles.
  - Required: wr_enable_o high exactly 2 cycles; addr_o=0x000010; wr_data_o=0xBEEF; m0_done_o pulses once; m0_err_o=0.
- Single m1 read:
  - Stimulus: addr=0xFFFFFF; rd_ready_i pulses with 0x1234 three cycles after busy_i.
  - Required: rd_enable_o high, wr_enable_o low; m1_done_o pulses the cycle after rd_ready_i; rd_data_o=0x1234.
- Both ports request continuously from reset (4 transfers):
  - Required grant order: m0, m1, m0, m1; no cycle with both enables high; no overlapping dones.
- Timeout with TIMEOUT=8:
  - Stimulus: busy_i held 0.
  - Required: m0_done_o and m0_err_o high together 9 cycles after the grant; rd_data_o unchanged; next request is serviced normally.
- Completion/timeout tie:
  - Stimulus: rd_ready_i arrives in the cycle tcnt==TIMEOUT-1.
  - Required: done with err=0; rd_data_o updated.
- Reset mid-transfer:
  - Stimulus: assert rst during WAIT of a write.
  - Required: enables, addr_o, and dones go to 0 immediately with no done pulse. After release, a pending m1 and m0 tie is granted to m0 first.
